// File: rtl/t05_huff_pkg.sv
// Shared types and constants for the Huffman decode path: node word layout,
// child encoding and the decoder state enum.
package t05_huff_pkg;

    localparam int NODE_W    = 71;
    localparam int IDX_W     = 7;
    localparam int CHAR_W    = 8;
    localparam int MAX_DEPTH = 127;
    localparam int DEPTH_W   = 8;
    localparam int CNT_W     = 16;

    // Node word: [70:64] max_index, [63:55] left, [54:46] right, [45:0] sum.
    localparam int MAXI_HI  = 70;
    localparam int MAXI_LO  = 64;
    localparam int LEFT_HI  = 63;
    localparam int RIGHT_HI = 54;
    localparam int SUM_W    = 46;
    localparam int CHILD_W  = 9;

    localparam logic [DEPTH_W-1:0] DEPTH_LIMIT = DEPTH_W'(MAX_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_BIT    = 3'd3,
        ST_EMIT   = 3'd4,
        ST_FINISH = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    // flag=1: val[6:0] is an internal node index; flag=0: val is a leaf char.
    typedef struct packed {
        logic              flag;
        logic [CHAR_W-1:0] val;
    } child_t;

    function automatic child_t pick_child(input logic [NODE_W-1:0] node,
                                          input logic bit_sel);
        child_t c;
        if (bit_sel) c = node[RIGHT_HI -: CHILD_W];
        else         c = node[LEFT_HI -: CHILD_W];
        return c;
    endfunction

endpackage

// File: rtl/t05_huff_node_sel.sv
// Combinational child selector: given a tree node word and a code bit, says
// whether the chosen child is a leaf and yields its char or node index.
module t05_huff_node_sel
    import t05_huff_pkg::*;
(
    input  logic [NODE_W-1:0] node,
    input  logic              bit_sel,
    output logic              is_leaf,
    output logic [CHAR_W-1:0] char_val,
    output logic [IDX_W-1:0]  next_index
);

    child_t child;
    logic   unused_bits;

    assign child      = pick_child(node, bit_sel);
    assign is_leaf    = ~child.flag;
    assign char_val   = child.val;
    assign next_index = child.val[IDX_W-1:0];

    // Header fields are carried in the node word but play no part in the walk.
    assign unused_bits = ^{node[MAXI_HI:MAXI_LO], node[SUM_W-1:0]};

endmodule

// File: rtl/t05_huff_decoder.sv
// Bit-serial Huffman decoder: walks the htree from the root, one node fetch per
// internal node, emitting a char per leaf. Optional char_count port behind
// T05_HUFF_DECODER_CHAR_COUNT_EN.
module t05_huff_decoder
    import t05_huff_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  max_index,
    output logic              node_req,
    output logic [IDX_W-1:0]  node_index,
    input  logic              node_valid,
    input  logic [NODE_W-1:0] h_element,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              bit_last,
    output logic              bit_ready,
    output logic              char_valid,
    output logic [CHAR_W-1:0] char_out,
    input  logic              char_ready,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef T05_HUFF_DECODER_CHAR_COUNT_EN
    ,
    output logic [CNT_W-1:0]  char_count
`endif
);

    // Handshakes: a bit moves on a rising edge where bit_valid && bit_ready;
    // a char moves where char_valid && char_ready, and char_valid/char_out
    // hold until that edge. node_valid is accepted only in WAIT.

    state_t              state;
    logic [IDX_W-1:0]    root_idx;
    logic [NODE_W-1:0]   cur_node;
    logic [NODE_W-1:0]   root_node;
    logic [DEPTH_W-1:0]  depth;
    logic                root_fetch;
    logic                last_char;

    logic                sel_leaf;
    logic [CHAR_W-1:0]   sel_char;
    logic [IDX_W-1:0]    sel_index;
    logic [DEPTH_W-1:0]  next_depth;

    t05_huff_node_sel u_node_sel (
        .node       (cur_node),
        .bit_sel    (bit_in),
        .is_leaf    (sel_leaf),
        .char_val   (sel_char),
        .next_index (sel_index)
    );

    assign next_depth = depth + DEPTH_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            root_idx   <= '0;
            cur_node   <= '0;
            root_node  <= '0;
            depth      <= '0;
            root_fetch <= 1'b0;
            last_char  <= 1'b0;
            node_req   <= 1'b0;
            node_index <= '0;
            bit_ready  <= 1'b0;
            char_valid <= 1'b0;
            char_out   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            node_req <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        root_idx   <= max_index;
                        node_index <= max_index;
                        node_req   <= 1'b1;
                        root_fetch <= 1'b1;
                        depth      <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (node_valid) begin
                        cur_node <= h_element;
                        if (root_fetch) root_node <= h_element;
                        root_fetch <= 1'b0;
                        bit_ready  <= 1'b1;
                        state      <= ST_BIT;
                    end
                end
                ST_BIT: begin
                    if (bit_valid) begin
                        depth     <= next_depth;
                        bit_ready <= 1'b0;
                        // Depth guard outranks everything, including a leaf.
                        if (next_depth > DEPTH_LIMIT) begin
                            err   <= 1'b1;
                            state <= ST_ERROR;
                        end else if (sel_leaf) begin
                            char_out   <= sel_char;
                            char_valid <= 1'b1;
                            last_char  <= bit_last;
                            state      <= ST_EMIT;
                        end else if (bit_last || (sel_index > root_idx)) begin
                            err   <= 1'b1;
                            state <= ST_ERROR;
                        end else begin
                            node_index <= sel_index;
                            node_req   <= 1'b1;
                            state      <= ST_FETCH;
                        end
                    end
                end
                ST_EMIT: begin
                    if (char_ready) begin
                        char_valid <= 1'b0;
                        if (last_char) begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            // Root word is cached, so the next code starts without a fetch.
                            cur_node  <= root_node;
                            depth     <= '0;
                            bit_ready <= 1'b1;
                            state     <= ST_BIT;
                        end
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_ERROR: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    bit_ready  <= 1'b0;
                    char_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef T05_HUFF_DECODER_CHAR_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_count <= '0;
        end else if (state == ST_IDLE && start) begin
            char_count <= '0;
        end else if (state == ST_EMIT && char_ready && char_count != '1) begin
            char_count <= char_count + CNT_W'(1);
        end
    end
`endif

    a_req_single: assert property (@(posedge clk) disable iff (rst)
        node_req |=> !node_req);
    a_char_hold: assert property (@(posedge clk) disable iff (rst)
        (char_valid && !char_ready) |=> (char_valid && $stable(char_out)));
    a_no_bit_in_emit: assert property (@(posedge clk) disable iff (rst)
        !(bit_ready && char_valid));

endmodule
